dmem_responder: RTL and testbench

- Data-memory responder: the target end of the memory-stage load/store interface.
- Accepts one 64-bit little-endian read or write request per transaction over a valid/ready handshake.
- Services the request after a fixed latency and returns the read data plus an error flag over a second valid/ready handshake.
- Replaces the zero-latency inline data memory so the memory stage can be verified against realistic stalls.

---
 rtl/dmem_responder_pkg.sv | 24 ++
 rtl/dmem_array.sv | 39 +++
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: Y86 word geometry,
// the stat encoding that resp_error maps onto, and the responder FSM states.
package dmem_responder_pkg;

    localparam int WORD_W     = 64;
    localparam int WORD_BYTES = 8;

    // Y86 status codes; a data-memory error surfaces as ADR, otherwise AOK.
    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_ADR = 3'd3
    } stat_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic stat_t resp_stat(input logic error);
        return error ? STAT_ADR : STAT_AOK;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-wide storage with a single 8-byte little-endian read/write port.
// The address arriving here is already range-checked by the responder, so
// addr..addr+7 always lands inside the array.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int   DEPTH_BYTES = 1024,
    localparam int  AW          = $clog2(DEPTH_BYTES)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic [WORD_W-1:0] dbg_word0
);

    logic [7:0] mem [DEPTH_BYTES];

    // Store eight consecutive bytes, lowest data byte at the lowest address.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                mem[addr + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    // Assemble the addressed word and the monitor word from the byte array.
    always_comb begin
        rdata     = '0;
        dbg_word0 = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rdata[8*i +: 8]     = mem[addr + AW'(i)];
            dbg_word0[8*i +: 8] = mem[AW'(i)];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Target end of the memory-stage load/store interface. Accepts one request,
// waits a fixed latency, commits the access on the edge entering RESP and
// holds the response until the requester takes it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [WORD_W-1:0] dbg_word0
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
    localparam logic [WORD_W-1:0] LAST_OK  = WORD_W'(DEPTH_BYTES - WORD_BYTES);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                write_q;
    logic [AW-1:0]       addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                err_q;

    logic                take_req;
    logic                req_err;
    logic                acc_write;
    logic [AW-1:0]       acc_addr;
    logic [WORD_W-1:0]   acc_wdata;
    logic                acc_err;
    logic                enter_resp;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [WORD_W-1:0]   mem_rdata;
    logic [WORD_W-1:0]   commit_rdata;

    // Select the live request on a single-cycle build's accepting edge,
    // otherwise the latched copy, and decide whether this edge commits.
    always_comb begin
        take_req     = (state == IDLE) && req_valid;
        req_err      = (req_addr > LAST_OK);
        acc_write    = take_req ? req_write : write_q;
        acc_addr     = take_req ? req_addr[AW-1:0] : addr_q;
        acc_wdata    = take_req ? req_wdata : wdata_q;
        acc_err      = take_req ? req_err : err_q;
        enter_resp   = (take_req && (LATENCY == 1)) || ((state == WAIT) && (cnt == '0));
        mem_we       = enter_resp && acc_write && !acc_err && !rst;
        mem_addr     = acc_err ? '0 : acc_addr;
        commit_rdata = (!acc_write && !acc_err) ? mem_rdata : '0;
    end

    dmem_array #(
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_array (
        .clk       (clk),
        .we        (mem_we),
        .addr      (mem_addr),
        .wdata     (acc_wdata),
        .rdata     (mem_rdata),
        .dbg_word0 (dbg_word0)
    );

    // Request/response sequencing with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        addr_q    <= req_addr[AW-1:0];
                        wdata_q   <= req_wdata;
                        err_q     <= req_err;
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= commit_rdata;
                            resp_error <= req_err;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= commit_rdata;
                        resp_error <= err_q;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_error <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 instance checked against
// a byte-array reference model, plus a LATENCY=1 instance for back-to-back flow.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk;
    logic        rst;

    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_error;
    logic [63:0] resp_rdata, dbg_word0;

    logic        req_valid_b, req_ready_b, req_write_b;
    logic [63:0] req_addr_b, req_wdata_b;
    logic        resp_valid_b, resp_ready_b, resp_error_b;
    logic [63:0] resp_rdata_b, dbg_word0_b;

    logic [7:0]  ref_mem [DEPTH];
    int          passed;
    int          total;

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .dbg_word0  (dbg_word0)
    );

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid_b),
        .req_ready  (req_ready_b),
        .req_write  (req_write_b),
        .req_addr   (req_addr_b),
        .req_wdata  (req_wdata_b),
        .resp_valid (resp_valid_b),
        .resp_ready (resp_ready_b),
        .resp_rdata (resp_rdata_b),
        .resp_error (resp_error_b),
        .dbg_word0  (dbg_word0_b)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit ref_err(input logic [63:0] a);
        return a > 64'(DEPTH - 8);
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] a);
        logic [63:0] r;
        r = '0;
        if (!ref_err(a))
            for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[int'(a) + i];
        return r;
    endfunction

    task automatic ref_store(input logic [63:0] a, input logic [63:0] d);
        if (!ref_err(a))
            for (int i = 0; i < 8; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
    endtask

    task automatic run_txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                           input bit release_resp,
                           output logic [63:0] rd, output logic er,
                           output logic [63:0] dbg, output int lat);
        int n;
        rd = '0; er = 1'b0; dbg = '0; lat = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            total++;
            $display("[TB] FAIL accept_timeout: req_ready=%b after %0d cycles, want 1", req_ready, n);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~w;
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
        do begin
            @(negedge clk);
            lat++;
        end while (resp_valid !== 1'b1 && lat < 20);
        if (resp_valid !== 1'b1) begin
            total++;
            $display("[TB] FAIL resp_timeout: resp_valid=%b after %0d cycles, want 1", resp_valid, lat);
            return;
        end
        rd = resp_rdata; er = resp_error; dbg = dbg_word0;
        if (release_resp) begin
            resp_ready = 1'b1;
            @(posedge clk);
            #1;
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready); else passed++;
        total++; if (resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid: got %b want 0", resp_valid); else passed++;
        total++; if (resp_rdata !== 64'h0) $display("[TB] FAIL reset_resp_rdata: got %h want 0", resp_rdata); else passed++;
        total++; if (resp_error !== 1'b0) $display("[TB] FAIL reset_resp_error: got %b want 0", resp_error); else passed++;
        total++; if (dbg_word0 !== 64'h0) $display("[TB] FAIL reset_dbg_word0: got %h want 0", dbg_word0); else passed++;
        total++; if (req_ready_b !== 1'b1) $display("[TB] FAIL reset_req_ready_b: got %b want 1", req_ready_b); else passed++;
    endtask

    task automatic test_store_load();
        logic [63:0] rd, dbg, exp;
        logic er;
        int lat;
        run_txn(1'b1, 64'd16, 64'h1122334455667788, 1'b1, rd, er, dbg, lat);
        ref_store(64'd16, 64'h1122334455667788);
        total++; if (lat != LAT) $display("[TB] FAIL store_latency: got %0d want %0d", lat, LAT); else passed++;
        total++; if (er !== 1'b0) $display("[TB] FAIL store_error: got %b want 0", er); else passed++;
        total++; if (rd !== 64'h0) $display("[TB] FAIL store_rdata: got %h want 0", rd); else passed++;
        exp = ref_load(64'd16);
        run_txn(1'b0, 64'd16, 64'h0, 1'b1, rd, er, dbg, lat);
        total++; if (rd !== exp) $display("[TB] FAIL load16_rdata: got %h want %h", rd, exp); else passed++;
        total++; if (lat != LAT) $display("[TB] FAIL load16_latency: got %0d want %0d", lat, LAT); else passed++;
        exp = ref_load(64'd17);
        run_txn(1'b0, 64'd17, 64'h0, 1'b1, rd, er, dbg, lat);
        total++; if (rd !== exp) $display("[TB] FAIL load17_rdata: got %h want %h", rd, exp); else passed++;
    endtask

    task automatic test_dbg_word0();
        logic [63:0] rd, dbg, exp;
        logic er;
        int lat;
        run_txn(1'b1, 64'd0, 64'hA5, 1'b1, rd, er, dbg, lat);
        ref_store(64'd0, 64'hA5);
        exp = ref_load(64'd0);
        total++; if (dbg !== exp) $display("[TB] FAIL dbg_word0: got %h want %h", dbg, exp); else passed++;
    endtask

    task automatic test_range();
        logic [63:0] rd, dbg, exp, d;
        logic er;
        int lat;
        d = {$urandom, $urandom};
        run_txn(1'b1, 64'd1016, d, 1'b1, rd, er, dbg, lat);
        ref_store(64'd1016, d);
        exp = ref_load(64'd1016);
        run_txn(1'b0, 64'd1016, 64'h0, 1'b1, rd, er, dbg, lat);
        total++; if (er !== 1'b0) $display("[TB] FAIL top_word_error: got %b want 0", er); else passed++;
        total++; if (rd !== exp) $display("[TB] FAIL top_word_rdata: got %h want %h", rd, exp); else passed++;
        run_txn(1'b0, 64'd1017, 64'h0, 1'b1, rd, er, dbg, lat);
        total++; if (er !== 1'b1) $display("[TB] FAIL over_error: got %b want 1", er); else passed++;
        total++; if (rd !== 64'h0) $display("[TB] FAIL over_rdata: got %h want 0", rd); else passed++;
        run_txn(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, {$urandom, $urandom}, 1'b1, rd, er, dbg, lat);
        total++; if (er !== 1'b1) $display("[TB] FAIL wrap_error: got %b want 1", er); else passed++;
        total++; if (rd !== 64'h0) $display("[TB] FAIL wrap_rdata: got %h want 0", rd); else passed++;
        exp = ref_load(64'd0);
        total++; if (dbg !== exp) $display("[TB] FAIL wrap_dbg_word0: got %h want %h", dbg, exp); else passed++;
        exp = ref_load(64'd1016);
        run_txn(1'b0, 64'd1016, 64'h0, 1'b1, rd, er, dbg, lat);
        total++; if (rd !== exp) $display("[TB] FAIL wrap_top_intact: got %h want %h", rd, exp); else passed++;
    endtask

    task automatic test_hold();
        logic [63:0] rd, dbg, exp;
        logic er;
        int lat;
        exp = ref_load(64'd16);
        run_txn(1'b0, 64'd16, 64'h0, 1'b0, rd, er, dbg, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (resp_valid !== 1'b1) $display("[TB] FAIL hold_valid[%0d]: got %b want 1", i, resp_valid); else passed++;
            total++; if (resp_rdata !== exp) $display("[TB] FAIL hold_rdata[%0d]: got %h want %h", i, resp_rdata, exp); else passed++;
            total++; if (resp_error !== 1'b0) $display("[TB] FAIL hold_error[%0d]: got %b want 0", i, resp_error); else passed++;
            total++; if (req_ready !== 1'b0) $display("[TB] FAIL hold_req_ready[%0d]: got %b want 0", i, req_ready); else passed++;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) $display("[TB] FAIL release_valid: got %b want 0", resp_valid); else passed++;
        total++; if (req_ready !== 1'b1) $display("[TB] FAIL release_req_ready: got %b want 1", req_ready); else passed++;
    endtask

    task automatic test_reset_discard();
        logic [63:0] rd, dbg, exp;
        logic er;
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd8; req_wdata = 64'hFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) $display("[TB] FAIL discard_valid: got %b want 0", resp_valid); else passed++;
        total++; if (req_ready !== 1'b1) $display("[TB] FAIL discard_req_ready: got %b want 1", req_ready); else passed++;
        exp = ref_load(64'd8);
        run_txn(1'b0, 64'd8, 64'h0, 1'b1, rd, er, dbg, lat);
        total++; if (rd !== exp) $display("[TB] FAIL discard_mem: got %h want %h", rd, exp); else passed++;
    endtask

    task automatic test_random();
        logic [63:0] rd, dbg, a, d, exp;
        logic er, w;
        int lat;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0, 1, 2: a = 64'($urandom_range(0, DEPTH - 8));
                3:       a = 64'($urandom_range(DEPTH - 7, DEPTH + 16));
                default: a = {$urandom, $urandom};
            endcase
            w = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom};
            exp = w ? 64'h0 : ref_load(a);
            run_txn(w, a, d, 1'b1, rd, er, dbg, lat);
            if (w) ref_store(a, d);
            total++; if (rd !== exp) $display("[TB] FAIL rand_rdata[%0d] addr=%h: got %h want %h", n, a, rd, exp); else passed++;
            total++; if (er !== ref_err(a)) $display("[TB] FAIL rand_error[%0d] addr=%h: got %b want %b", n, a, er, ref_err(a)); else passed++;
            total++; if (lat != LAT) $display("[TB] FAIL rand_latency[%0d]: got %0d want %0d", n, lat, LAT); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] addr_s, data_s, exp;
        @(negedge clk);
        addr_s = '0; data_s = '0; exp = '0;
        for (int c = 0; c < 20; c++) begin
            total++; if (req_ready_b !== ((c % 2) == 0)) $display("[TB] FAIL b2b_ready[%0d]: got %b want %b", c, req_ready_b, (c % 2) == 0); else passed++;
            total++; if (resp_valid_b !== ((c % 2) == 1)) $display("[TB] FAIL b2b_valid[%0d]: got %b want %b", c, resp_valid_b, (c % 2) == 1); else passed++;
            if ((c % 2) == 1) begin
                total++; if (resp_rdata_b !== exp) $display("[TB] FAIL b2b_rdata[%0d]: got %h want %h", c, resp_rdata_b, exp); else passed++;
            end else if (((c / 2) % 2) == 0) begin
                addr_s = 64'($urandom_range(0, DEPTH - 8));
                data_s = {$urandom, $urandom};
                req_valid_b = 1'b1; req_write_b = 1'b1; req_addr_b = addr_s; req_wdata_b = data_s;
                exp = 64'h0;
            end else begin
                req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = addr_s; req_wdata_b = '0;
                exp = data_s;
            end
            @(negedge clk);
        end
        req_valid_b = 1'b0;
    endtask

    // Test sequence.
    initial begin
        passed = 0; total = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; resp_ready_b = 1'b1;
        test_reset();
        test_store_load();
        test_dbg_word0();
        test_range();
        test_hold();
        test_reset_discard();
        test_random();
        test_back_to_back();
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
